// File: rtl/system2_onchip_mem_arbiter_if.sv
// One Avalon-MM master bundle toward the on-chip memory arbiter.
// The master drives the command fields; the arbiter drives the stall and the read return.
interface system2_onchip_mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  // Handshake: a command (read or write high) is accepted in a cycle where waitrequest is low.
  // A command that is not accepted must be held. An accepted read returns its data with
  // readdatavalid exactly one cycle later. An accepted write needs no response.
  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/system2_onchip_mem_arbiter.sv
// Two-master round-robin arbiter in front of one single-port on-chip RAM (registered address, unregistered q).
// Optional saturating contention counter output is enabled with the macro OCM_ARB_CONTENTION_CNT_EN.
module system2_onchip_mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  system2_onchip_mem_arbiter_if.slave m0,
  system2_onchip_mem_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata
`ifdef OCM_ARB_CONTENTION_CNT_EN
  ,
  output logic [CNT_W-1:0]      contention_cnt
`endif
);

  logic req0;
  logic req1;
  logic grant0;
  logic grant1;
  logic last_grant;
  logic rd_pend;
  logic rd_id;

  // A master with the other one idle always wins; under contention the loser of the last grant wins.
  always_comb begin
    req0   = m0.read | m0.write;
    req1   = m1.read | m1.write;
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (req0 && (!req1 || last_grant)) begin
        grant0 = 1'b1;
      end else if (req1) begin
        grant1 = 1'b1;
      end
    end
  end

  // Read-with-write from the same master is a write, so byteenable is honoured only then.
  always_comb begin
    mem_chipselect = grant0 | grant1;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    if (grant0) begin
      mem_address    = m0.address;
      mem_write      = m0.write;
      mem_byteenable = m0.write ? m0.byteenable : '1;
      mem_writedata  = m0.writedata;
    end else if (grant1) begin
      mem_address    = m1.address;
      mem_write      = m1.write;
      mem_byteenable = m1.write ? m1.byteenable : '1;
      mem_writedata  = m1.writedata;
    end
  end

  assign mem_clken = 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      rd_pend    <= 1'b0;
      rd_id      <= 1'b0;
    end else begin
      if (grant0) begin
        last_grant <= 1'b0;
      end else if (grant1) begin
        last_grant <= 1'b1;
      end
      rd_pend <= (grant0 & ~m0.write) | (grant1 & ~m1.write);
      rd_id   <= grant1;
    end
  end

  assign m0.waitrequest = req0 & ~grant0;
  assign m1.waitrequest = req1 & ~grant1;

  // Gating with reset also drops a read accepted just before reset asserted.
  assign m0.readdatavalid = rd_pend & ~rd_id & ~reset;
  assign m1.readdatavalid = rd_pend & rd_id & ~reset;
  assign m0.readdata      = mem_readdata;
  assign m1.readdata      = mem_readdata;

`ifdef OCM_ARB_CONTENTION_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      contention_cnt <= '0;
    end else if (req0 && req1 && (contention_cnt != {CNT_W{1'b1}})) begin
      contention_cnt <= contention_cnt + 1'b1;
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_system2_onchip_mem_arbiter.sv
// Self-checking bench for the two-master on-chip memory arbiter with a behavioural RAM and reference model.
// Build with OCM_ARB_CONTENTION_CNT_EN defined to also check the contention counter.
module tb_system2_onchip_mem_arbiter;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  system2_onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_bus ();
  system2_onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_bus ();

  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;
`ifdef OCM_ARB_CONTENTION_CNT_EN
  logic [CNT_W-1:0]  contention_cnt;
`endif

  system2_onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (rst),
    .m0             (m0_bus),
    .m1             (m1_bus),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata)
`ifdef OCM_ARB_CONTENTION_CNT_EN
    ,
    .contention_cnt (contention_cnt)
`endif
  );

  // ---------------- single-port RAM: registered address, unregistered q ----------------
  logic [DATA_W-1:0] ram [1024];
  logic [ADDR_W-1:0] ram_addr_q = '0;
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end
      ram_addr_q <= mem_address;
    end
  end
  assign mem_readdata = ram[ram_addr_q];

  // ---------------- reference model / scoreboard ----------------
  logic [DATA_W-1:0] model_mem [1024];
  logic [DATA_W-1:0] exp_q [$];
  int   last_win   = 1;
  bit   pend_valid = 1'b0;
  int   pend_id    = 0;
  int   model_cnt  = 0;
  int   n_assert   = 0;
  int   n_fail     = 0;
  int   n_v0       = 0;
  int   n_v1       = 0;
  logic [DATA_W-1:0] last_rd0;
  logic [DATA_W-1:0] last_rd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int id, input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                       input logic [3:0] be, input logic [DATA_W-1:0] d);
    if (id == 0) begin
      m0_bus.read = rd; m0_bus.write = wr; m0_bus.address = a;
      m0_bus.byteenable = be; m0_bus.writedata = d;
    end else begin
      m1_bus.read = rd; m1_bus.write = wr; m1_bus.address = a;
      m1_bus.byteenable = be; m1_bus.writedata = d;
    end
  endtask

  task automatic idle();
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // One bus cycle: check outputs against the model mid-cycle, then advance the model at the edge.
  task automatic step();
    bit r0, r1, w_wr, ev0, ev1;
    int win;
    logic [ADDR_W-1:0] w_a;
    logic [3:0]        w_be;
    logic [DATA_W-1:0] w_d, e;
    r0 = m0_bus.read | m0_bus.write;
    r1 = m1_bus.read | m1_bus.write;
    #1;
    if (rst)             win = -1;
    else if (r0 && r1)   win = 1 - last_win;
    else if (r0)         win = 0;
    else if (r1)         win = 1;
    else                 win = -1;
    w_wr = (win == 0) ? m0_bus.write      : m1_bus.write;
    w_a  = (win == 0) ? m0_bus.address    : m1_bus.address;
    w_be = (win == 0) ? m0_bus.byteenable : m1_bus.byteenable;
    w_d  = (win == 0) ? m0_bus.writedata  : m1_bus.writedata;

    chk("m0_wait", m0_bus.waitrequest, r0 && win != 0);
    chk("m1_wait", m1_bus.waitrequest, r1 && win != 1);
    ev0 = !rst && pend_valid && pend_id == 0;
    ev1 = !rst && pend_valid && pend_id == 1;
    chk("m0_rdv", m0_bus.readdatavalid, ev0);
    chk("m1_rdv", m1_bus.readdatavalid, ev1);
    if (ev0 || ev1) begin
      e = exp_q.pop_front();
      if (ev0) chk("m0_rdata", m0_bus.readdata, e);
      else     chk("m1_rdata", m1_bus.readdata, e);
    end
    if (m0_bus.readdatavalid === 1'b1) begin n_v0++; last_rd0 = m0_bus.readdata; end
    if (m1_bus.readdatavalid === 1'b1) begin n_v1++; last_rd1 = m1_bus.readdata; end
    chk("mem_cs", mem_chipselect, win >= 0);
    chk("mem_we", mem_write, win >= 0 && w_wr);
    if (win >= 0) begin
      chk("mem_addr", mem_address, w_a);
      chk("mem_be", mem_byteenable, w_wr ? w_be : 4'hF);
      if (w_wr) chk("mem_wdata", mem_writedata, w_d);
    end

    @(posedge clk);
    if (rst) begin
      pend_valid = 1'b0;
      exp_q.delete();
      last_win  = 1;
      model_cnt = 0;
    end else begin
      if (r0 && r1 && model_cnt < 65535) model_cnt++;
      pend_valid = 1'b0;
      if (win >= 0) begin
        last_win = win;
        if (w_wr) begin
          for (int b = 0; b < 4; b++)
            if (w_be[b]) model_mem[w_a][8*b +: 8] = w_d[8*b +: 8];
        end else begin
          pend_valid = 1'b1;
          pend_id    = win;
          exp_q.push_back(model_mem[w_a]);
        end
      end
    end
    @(negedge clk);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i]       = i * 32'h9E3779B9;
      model_mem[i] = i * 32'h9E3779B9;
    end
    idle();
    rst = 1'b1;
    step();
    step();
    // Requests during reset must stall with no memory access.
    drive(0, 1'b1, 1'b0, 10'h001, 4'h0, '0);
    drive(1, 1'b0, 1'b1, 10'h002, 4'hF, 32'h1111_2222);
    step();
    idle();
    rst = 1'b0;
    step();

    // Full-word write then read-back from m0.
    n_v0 = 0; n_v1 = 0;
    drive(0, 1'b0, 1'b1, 10'h010, 4'hF, 32'hDEADBEEF);
    step();
    drive(0, 1'b1, 1'b0, 10'h010, 4'h0, '0);
    step();
    idle();
    step();
    chk("t1_rdata", last_rd0, 32'hDEADBEEF);
    chk("t1_m0_cnt", n_v0, 1);
    chk("t1_m1_cnt", n_v1, 0);

    // Byte-lane write from m1 merges into existing word.
    drive(1, 1'b0, 1'b1, 10'h010, 4'b0001, 32'h0000_00AA);
    step();
    drive(1, 1'b1, 1'b0, 10'h010, 4'h0, '0);
    step();
    idle();
    step();
    chk("t2_rdata", last_rd1, 32'hDEADBEAA);

    // Continuous contention after reset: strict alternation, m0 first.
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_v0 = 0; n_v1 = 0;
    drive(0, 1'b1, 1'b0, 10'h000, 4'h0, '0);
    drive(1, 1'b1, 1'b0, 10'h001, 4'h0, '0);
    #1;
    chk("t3_first_m0_wait", m0_bus.waitrequest, 1'b0);
    chk("t3_first_m1_wait", m1_bus.waitrequest, 1'b1);
    repeat (8) step();
    idle();
    step();
    chk("t3_m0_cnt", n_v0, 4);
    chk("t3_m1_cnt", n_v1, 4);
    chk("t3_m0_data", last_rd0, 32'h0);
    chk("t3_m1_data", last_rd1, 32'h9E3779B9);
`ifdef OCM_ARB_CONTENTION_CNT_EN
    chk("t3_contention", contention_cnt, 16'd8);
`endif

    // Read accepted just before reset must never return.
    n_v0 = 0; n_v1 = 0;
    drive(0, 1'b1, 1'b0, 10'h005, 4'h0, '0);
    step();
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
    chk("t4_m0_cnt", n_v0, 0);
    chk("t4_m1_cnt", n_v1, 0);
    drive(0, 1'b1, 1'b0, 10'h006, 4'h0, '0);
    drive(1, 1'b1, 1'b0, 10'h007, 4'h0, '0);
    #1;
    chk("t4_m0_first", m0_bus.waitrequest, 1'b0);
    step();
    idle();
    step();

    // Read and write together is a write.
    n_v0 = 0;
    drive(0, 1'b1, 1'b1, 10'h3FF, 4'hF, 32'h12345678);
    step();
    idle();
    step();
    chk("t5_no_rdv", n_v0, 0);
    drive(0, 1'b1, 1'b0, 10'h3FF, 4'h0, '0);
    step();
    idle();
    step();
    chk("t5_rdata", last_rd0, 32'h12345678);

    // Random traffic against the model, including same-address hazards and occasional resets.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int m = 0; m < 2; m++) begin
        if ($urandom_range(0, 3) != 0)
          drive(m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                10'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), $urandom);
        else
          drive(m, 1'b0, 1'b0, 10'($urandom_range(0, 7)), 4'h0, $urandom);
      end
      step();
    end
    rst = 1'b0;
    idle();
    step();
`ifdef OCM_ARB_CONTENTION_CNT_EN
    chk("rand_contention", contention_cnt, model_cnt);

    // Saturation: counter must hold at all-ones.
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 10'h000, 4'h0, '0);
    drive(1, 1'b1, 1'b0, 10'h001, 4'h0, '0);
    repeat (65541) @(posedge clk);
    @(negedge clk);
    chk("sat_cnt", contention_cnt, 16'hFFFF);
    @(posedge clk);
    @(negedge clk);
    chk("sat_hold", contention_cnt, 16'hFFFF);
    idle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
